// File: rtl/pe_config_loader.sv
// pe_config_loader: clears the PE array, streams host instruction words into per-PE config
// buffers over a shared bus, then runs the loaded configuration for DEPTH cycles and drains.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   cfg_start           pulse: begin clear+load
//   cfg_valid/cfg_data  host instruction stream, accepted when cfg_ready
//   cfg_ready           high only while loading
//   run_start           pulse: execute the loaded configuration
//   pe_rst              PE array reset (reset and the single CLEAR cycle)
//   pe_inst/pe_init     shared instruction bus and one-hot per-PE write strobe
//   pe_run              broadcast run enable, DEPTH cycles
//   busy/loaded         status
//   done/error          single-cycle pulses
module pe_config_loader #(
  parameter int INST_W    = 48,
  parameter int NUM_PE    = 16,
  parameter int DEPTH     = 4,
  parameter int DRAIN_CYC = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_start,
  input  logic              cfg_valid,
  input  logic [INST_W-1:0] cfg_data,
  output logic              cfg_ready,
  input  logic              run_start,
  output logic              pe_rst,
  output logic [INST_W-1:0] pe_inst,
  output logic [NUM_PE-1:0] pe_init,
  output logic              pe_run,
  output logic              busy,
  output logic              loaded,
  output logic              done,
  output logic              error
);
  localparam int WORDS = NUM_PE * DEPTH;
  localparam int WW = $clog2(WORDS);
  localparam int RW = $clog2(DEPTH + 1);
  localparam int DW = $clog2(DRAIN_CYC + 1);

  typedef enum logic [2:0] {IDLE, CLEAR, LOAD, ARMED, RUN, DRAIN, DONE} state_t;

  state_t state, state_n;
  logic [WW-1:0] word_cnt, word_cnt_n;
  logic [RW-1:0] run_cnt, run_cnt_n;
  logic [DW-1:0] drain_cnt, drain_cnt_n;
  logic [INST_W-1:0] inst_n;
  logic [NUM_PE-1:0] init_n;
  logic loaded_n, error_n;

  // All outputs are registered from the next-state decode so they line up with the state.
  always_comb begin
    state_n = state;
    word_cnt_n = word_cnt;
    run_cnt_n = run_cnt;
    drain_cnt_n = drain_cnt;
    inst_n = pe_inst;
    init_n = '0;
    loaded_n = loaded;
    error_n = cfg_start | run_start;
    case (state)
      IDLE: begin
        error_n = run_start & ~cfg_start;
        state_n = cfg_start ? CLEAR : IDLE;
      end
      CLEAR: begin
        state_n = LOAD;
        word_cnt_n = '0;
      end
      LOAD: if (cfg_valid && cfg_ready) begin
        inst_n = cfg_data;
        init_n = NUM_PE'(1) << (word_cnt / DEPTH);
        word_cnt_n = word_cnt + WW'(1);
        if (word_cnt == WW'(WORDS - 1)) begin
          state_n = ARMED;
          loaded_n = 1'b1;
        end
      end
      ARMED: begin
        error_n = 1'b0;
        // cfg_start takes priority over run_start when both arrive together.
        if (cfg_start) begin
          state_n = CLEAR;
          loaded_n = 1'b0;
        end else if (run_start) begin
          state_n = RUN;
          run_cnt_n = '0;
        end
      end
      RUN: begin
        run_cnt_n = run_cnt + RW'(1);
        if (run_cnt == RW'(DEPTH - 1)) begin
          state_n = DRAIN;
          drain_cnt_n = '0;
        end
      end
      DRAIN: begin
        drain_cnt_n = drain_cnt + DW'(1);
        if (drain_cnt == DW'(DRAIN_CYC - 1)) begin
          state_n = DONE;
          loaded_n = 1'b0;
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      word_cnt <= '0;
      run_cnt <= '0;
      drain_cnt <= '0;
      pe_rst <= 1'b1;
      cfg_ready <= 1'b0;
      pe_inst <= '0;
      pe_init <= '0;
      pe_run <= 1'b0;
      busy <= 1'b0;
      loaded <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
    end else begin
      state <= state_n;
      word_cnt <= word_cnt_n;
      run_cnt <= run_cnt_n;
      drain_cnt <= drain_cnt_n;
      pe_rst <= state_n == CLEAR;
      cfg_ready <= state_n == LOAD;
      pe_inst <= inst_n;
      pe_init <= init_n;
      pe_run <= state_n == RUN;
      busy <= !(state_n inside {IDLE, ARMED});
      loaded <= loaded_n;
      done <= state_n == DONE;
      error <= error_n;
    end
  end
endmodule

// File: tb/tb_pe_config_loader.sv
// tb_pe_config_loader: randomized self-checking bench for pe_config_loader.
module tb_pe_config_loader;
  localparam int INST_W = 48;
  localparam int NUM_PE = 16;
  localparam int DEPTH = 4;
  localparam int WORDS = NUM_PE * DEPTH;

  logic clk = 1'b0;
  logic rst, cfg_start, cfg_valid, run_start;
  logic [INST_W-1:0] cfg_data;
  logic cfg_ready, pe_rst, pe_run, busy, loaded, done, error;
  logic [INST_W-1:0] pe_inst;
  logic [NUM_PE-1:0] pe_init;
  int total = 0;
  int bad = 0;

  pe_config_loader dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_data(cfg_data),
    .cfg_ready(cfg_ready), .run_start(run_start), .pe_rst(pe_rst), .pe_inst(pe_inst),
    .pe_init(pe_init), .pe_run(pe_run), .busy(busy), .loaded(loaded), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick;
    tick;
    total++;
    if ({pe_rst, cfg_ready, pe_run, busy, loaded, done, error} !== 7'b1000000 || pe_init !== '0 || pe_inst !== '0) begin
      bad++;
      $display("FAIL reset_vals: got rst/rdy/run/busy/ld/done/err=%b init=%h inst=%h want 1000000 0 0",
               {pe_rst, cfg_ready, pe_run, busy, loaded, done, error}, pe_init, pe_inst);
    end
    rst = 1'b0;
    tick;
    total++;
    if (pe_rst !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: got pe_rst=%b busy=%b want 0 0", pe_rst, busy);
    end
  endtask

  // mode 0: back-to-back with data=index, 1: valid toggling, 2: random valid and data.
  // abort_at >= 0 asserts rst right after that word is accepted.
  task automatic do_load(input int mode, input int abort_at);
    int i, cyc, strobes, init_err, inst_err, ld_err, rdy_err;
    logic v;
    logic [INST_W-1:0] d;
    logic [NUM_PE-1:0] exp_init;
    cfg_start = 1'b1;
    tick;
    cfg_start = 1'b0;
    total++;
    if (pe_rst !== 1'b1 || cfg_ready !== 1'b0 || busy !== 1'b1 || loaded !== 1'b0) begin
      bad++;
      $display("FAIL clear_cycle: got pe_rst=%b rdy=%b busy=%b ld=%b want 1 0 1 0", pe_rst, cfg_ready, busy, loaded);
    end
    tick;
    total++;
    if (pe_rst !== 1'b0 || cfg_ready !== 1'b1) begin
      bad++;
      $display("FAIL load_entry: got pe_rst=%b rdy=%b want 0 1", pe_rst, cfg_ready);
    end
    i = 0;
    cyc = 0;
    strobes = 0;
    init_err = 0;
    inst_err = 0;
    ld_err = 0;
    rdy_err = 0;
    while (i < WORDS && cyc < 1000) begin
      v = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      d = mode == 0 ? INST_W'(i) : {16'($urandom), $urandom};
      cfg_valid = v;
      cfg_data = d;
      tick;
      cyc++;
      exp_init = v ? NUM_PE'(1) << (i / DEPTH) : '0;
      if (pe_init !== '0) strobes++;
      if (pe_init !== exp_init) begin
        init_err++;
        $display("FAIL load_init word %0d: got %h want %h", i, pe_init, exp_init);
      end
      if (v && pe_inst !== d) begin
        inst_err++;
        $display("FAIL load_inst word %0d: got %h want %h", i, pe_inst, d);
      end
      if (loaded !== (v && i == WORDS - 1)) ld_err++;
      if (cfg_ready !== !(v && i == WORDS - 1)) rdy_err++;
      if (v) begin
        if (i == abort_at) begin
          rst = 1'b1;
          tick;
          rst = 1'b0;
          cfg_valid = 1'b0;
          total++;
          if (pe_init !== '0 || pe_rst !== 1'b1 || cfg_ready !== 1'b0 || loaded !== 1'b0) begin
            bad++;
            $display("FAIL abort_reset: got init=%h pe_rst=%b rdy=%b ld=%b want 0 1 0 0", pe_init, pe_rst, cfg_ready, loaded);
          end
          tick;
          total++;
          if (pe_rst !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL abort_release: got pe_rst=%b busy=%b want 0 0", pe_rst, busy);
          end
          return;
        end
        i++;
      end
    end
    total++;
    if (init_err != 0 || inst_err != 0) bad++;
    total++;
    if (strobes != WORDS || i != WORDS) begin
      bad++;
      $display("FAIL strobe_count: got %0d strobes %0d words want %0d", strobes, i, WORDS);
    end
    total++;
    if (ld_err != 0 || rdy_err != 0) begin
      bad++;
      $display("FAIL load_status: got %0d loaded errors %0d ready errors want 0 0", ld_err, rdy_err);
    end
    cfg_valid = 1'b1;
    cfg_data = {16'($urandom), $urandom};
    tick;
    cfg_valid = 1'b0;
    total++;
    if (pe_init !== '0 || cfg_ready !== 1'b0 || busy !== 1'b0 || loaded !== 1'b1 || error !== 1'b0) begin
      bad++;
      $display("FAIL armed_state: got init=%h rdy=%b busy=%b ld=%b err=%b want 0 0 0 1 0", pe_init, cfg_ready, busy, loaded, error);
    end
  endtask

  // inj > 0 pulses cfg_start in run cycle inj; the error appears one cycle later.
  task automatic do_run(input int inj);
    int runs, first, last, dones, done_at, err_at;
    runs = 0;
    first = -1;
    last = -1;
    dones = 0;
    done_at = -1;
    err_at = -1;
    run_start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick;
      run_start = 1'b0;
      cfg_start = (c == inj);
      if (pe_run) begin
        runs++;
        if (first < 0) first = c;
        last = c;
      end
      if (done) begin
        dones++;
        done_at = c;
      end
      if (error && err_at < 0) err_at = c;
    end
    cfg_start = 1'b0;
    total++;
    if (runs != DEPTH || first != 1 || last != DEPTH) begin
      bad++;
      $display("FAIL run_len: got %0d cycles first %0d last %0d want %0d 1 %0d", runs, first, last, DEPTH, DEPTH);
    end
    total++;
    if (dones != 1 || done_at != 8) begin
      bad++;
      $display("FAIL done_timing: got %0d pulses at %0d want 1 at 8", dones, done_at);
    end
    total++;
    if (err_at != (inj > 0 ? inj + 1 : -1)) begin
      bad++;
      $display("FAIL run_error: got first error at %0d want %0d", err_at, inj > 0 ? inj + 1 : -1);
    end
    total++;
    if (loaded !== 1'b0 || busy !== 1'b0 || pe_run !== 1'b0) begin
      bad++;
      $display("FAIL after_done: got ld=%b busy=%b run=%b want 0 0 0", loaded, busy, pe_run);
    end
  endtask

  task automatic test_idle_run_error;
    run_start = 1'b1;
    tick;
    run_start = 1'b0;
    total++;
    if (error !== 1'b1 || busy !== 1'b0 || pe_run !== 1'b0) begin
      bad++;
      $display("FAIL idle_run_err: got err=%b busy=%b run=%b want 1 0 0", error, busy, pe_run);
    end
    tick;
    total++;
    if (error !== 1'b0) begin
      bad++;
      $display("FAIL idle_err_pulse: got err=%b want 0", error);
    end
  endtask

  task automatic test_collision;
    int runs;
    do_load(2, -1);
    cfg_start = 1'b1;
    run_start = 1'b1;
    tick;
    cfg_start = 1'b0;
    run_start = 1'b0;
    total++;
    if (pe_rst !== 1'b1 || error !== 1'b0 || pe_run !== 1'b0 || loaded !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL collision: got pe_rst=%b err=%b run=%b ld=%b busy=%b want 1 0 0 0 1", pe_rst, error, pe_run, loaded, busy);
    end
    runs = 0;
    for (int c = 0; c < 6; c++) begin
      tick;
      if (pe_run) runs++;
    end
    total++;
    if (runs != 0 || cfg_ready !== 1'b1) begin
      bad++;
      $display("FAIL collision_norun: got %0d run cycles rdy=%b want 0 1", runs, cfg_ready);
    end
  endtask

  initial begin
    rst = 1'b1;
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
    run_start = 1'b0;
    cfg_data = '0;
    test_reset;
    do_load(0, -1);
    do_run(0);
    test_idle_run_error;
    do_load(1, -1);
    do_run(2);
    do_load(2, 20);
    do_load(2, -1);
    do_run(0);
    test_collision;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
